// File: rtl/mem_port_arbiter_pkg.sv
// Shared state/owner encodings and latency-counter width for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick (bit0 = fetch, bit1 = data); purely combinational, no latency.
// On a conflict the side that did not win last time is chosen; no backpressure of its own.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic [1:0] grant,
  output logic       conflict
);

  always_comb begin
    conflict = req[0] & req[1];
    grant    = req;
    if (conflict) begin
      grant = (last_owner == OWN_FETCH) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto one single-port memory; req edge -> gnt +1, rvalid +2+MEM_LAT.
// Requests are held by the requester until gnt; one transaction per MEM_LAT+2 cycles, arbitration only in IDLE/RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] Address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_data,
  output logic [31:0]       conflict_cnt
);

  state_t            state, state_nxt;
  owner_t            owner, last_owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [1:0]        grant;
  logic              conflict;
  logic              arb_cyc, take;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, if_req}),
    .last_owner (last_owner),
    .grant      (grant),
    .conflict   (conflict)
  );

  assign arb_cyc = (state == ST_IDLE) || (state == ST_RESP);
  assign take    = arb_cyc && (|grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      ST_IDLE: state_nxt = take ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if_gnt    = (owner == OWN_FETCH);
        d_gnt     = (owner == OWN_DATA);
        MemRead   = !we_q;
        MemWrite  = we_q;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (lat_cnt == '0) state_nxt = ST_RESP;
      ST_RESP: begin
        if_rvalid = (owner == OWN_FETCH);
        d_rvalid  = (owner == OWN_DATA);
        state_nxt = take ? ST_ISSUE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are captured only on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_FETCH;
      last_owner <= OWN_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (take) begin
        owner      <= grant[1] ? OWN_DATA : OWN_FETCH;
        last_owner <= grant[1] ? OWN_DATA : OWN_FETCH;
        addr_q     <= grant[1] ? d_addr : if_addr;
        we_q       <= grant[1] & d_we;
        if (grant[1]) wdata_q <= d_wdata;
      end
      if (state == ST_ISSUE) lat_cnt <= LAT_W'(MEM_LAT - 1);
      if (state == ST_WAIT) begin
        if (lat_cnt == '0) begin
          if (owner == OWN_FETCH) if_rdata_q <= Read_data;
          else                    d_rdata_q  <= we_q ? '0 : Read_data;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              conflict_cnt <= '0;
    else if (arb_cyc && conflict && conflict_cnt != '1)   conflict_cnt <= conflict_cnt + 32'd1;
  end

  assign Address    = addr_q;
  assign Write_data = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule
